// File: rtl/rf_cmd_sched.sv
// Register-file command scheduler: buffers move/ldst commands and runs them one
// at a time on the selected engine, steering the RF RAM mux only between commands.
module rf_cmd_sched #(
  parameter int PAYLOAD_W      = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_type_i,
  input  logic [PAYLOAD_W-1:0]          cmd_payload_i,
  output logic                          ram_sel_o,
  output logic                          move_start_o,
  output logic                          ldst_start_o,
  output logic [PAYLOAD_W-1:0]          eng_payload_o,
  input  logic                          move_done_i,
  input  logic                          ldst_done_i,
  output logic                          cmd_done_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          err_timeout_o,
  input  logic                          err_clr_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_START, S_WAIT} state_e;

  state_e                 state_q;
  logic                   cur_type_q;
  logic                   ram_sel_q;
  logic                   move_start_q;
  logic                   ldst_start_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic                   cmd_done_q;
  logic                   err_q;
  logic [TIMEOUT_W-1:0]   wd_q;

  // FIFO entries carry the command type in the MSB above the payload
  logic [PAYLOAD_W:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  logic                   push;
  logic                   pop;
  logic [PAYLOAD_W:0]     head;
  logic                   sel_done;
  logic                   wd_expire;

  assign cmd_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
  assign sel_done    = cur_type_q ? ldst_done_i : move_done_i;
  assign wd_expire   = WD_EN && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_type_i, cmd_payload_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_type_q   <= 1'b0;
      ram_sel_q    <= 1'b0;
      move_start_q <= 1'b0;
      ldst_start_q <= 1'b0;
      payload_q    <= '0;
      cmd_done_q   <= 1'b0;
      err_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      move_start_q <= 1'b0;
      ldst_start_q <= 1'b0;
      cmd_done_q   <= 1'b0;
      if (err_clr_i) err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_type_q <= head[PAYLOAD_W];
            ram_sel_q  <= head[PAYLOAD_W];
            payload_q  <= head[PAYLOAD_W-1:0];
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          move_start_q <= !cur_type_q;
          ldst_start_q <= cur_type_q;
          state_q      <= S_START;
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // a done coinciding with expiry is a normal completion
          if (sel_done) begin
            cmd_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (wd_expire) begin
            err_q      <= 1'b1;
            cmd_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (wd_q != WD_MAX) begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_sel_o     = ram_sel_q;
  assign move_start_o  = move_start_q;
  assign ldst_start_o  = ldst_start_q;
  assign eng_payload_o = payload_q;
  assign cmd_done_o    = cmd_done_q;
  assign err_timeout_o = err_q;
  assign fifo_count_o  = count_q;
  assign busy_o        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_rf_cmd_sched.sv
// Randomised scoreboard bench for rf_cmd_sched against a cycle-timeline model
// built from the command queue, the dispatch timing and the watchdog rule.
module tb_rf_cmd_sched;
  localparam int PW = 64;
  localparam int DEPTH = 4;
  localparam int TW = 16;
  localparam int TC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_type = 1'b0;
  logic [PW-1:0] cmd_payload = '0, eng_payload;
  logic ram_sel, move_start, ldst_start;
  logic move_done = 1'b0, ldst_done = 1'b0;
  logic cmd_done, busy, err_timeout, err_clr = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  rf_cmd_sched #(
    .PAYLOAD_W(PW), .FIFO_DEPTH(DEPTH), .TIMEOUT_W(TW), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_type_i(cmd_type),
    .cmd_payload_i(cmd_payload), .ram_sel_o(ram_sel), .move_start_o(move_start),
    .ldst_start_o(ldst_start), .eng_payload_o(eng_payload), .move_done_i(move_done),
    .ldst_done_i(ldst_done), .cmd_done_o(cmd_done), .busy_o(busy),
    .fifo_count_o(fifo_count), .err_timeout_o(err_timeout), .err_clr_i(err_clr)
  );

  typedef struct packed {logic t; logic [PW-1:0] p;} cmd_t;
  cmd_t sb_q[$];
  cmd_t mq[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  bit resp_en = 1'b1, resp_wrong = 1'b0, noise_en = 1'b0;
  int dmin = 3, dmax = 3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // entered and left at posedge+1; leaves cmd_valid high for back-to-back use
  task automatic push(input logic t, input logic [PW-1:0] p);
    bit acc = 1'b0;
    cmd_t e;
    cmd_valid = 1'b1; cmd_type = t; cmd_payload = p;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    if (acc) begin
      e.t = t; e.p = p;
      sb_q.push_back(e);
    end else begin
      chk("push_accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) chk("drain_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_ram_sel", ram_sel, 0);
    chk("rst_move_start", move_start, 0);
    chk("rst_ldst_start", ldst_start, 0);
    chk("rst_eng_payload", eng_payload, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
  endtask

  // engine stand-in plus optional stray done pulses; the model does not rely on it
  initial begin : responder
    bit s_mv, s_ld, pend_t, wrong_pend;
    int cd;
    cd = -1; pend_t = 1'b0; wrong_pend = 1'b0;
    forever begin
      @(negedge clk);
      s_mv = move_start; s_ld = ldst_start;
      @(posedge clk); #1;
      move_done = 1'b0; ldst_done = 1'b0;
      if (!rst_n) begin cd = -1; wrong_pend = 1'b0; end
      if (s_mv || s_ld) begin
        pend_t = s_ld;
        cd = resp_en ? $urandom_range(dmax, dmin) : -1;
        wrong_pend = resp_wrong;
      end
      if (wrong_pend) begin
        if (pend_t) move_done = 1'b1; else ldst_done = 1'b1;
        wrong_pend = 1'b0;
      end
      if (cd == 0) begin
        if (pend_t) ldst_done = 1'b1; else move_done = 1'b1;
      end
      if (cd >= 0) cd--;
      if (noise_en && $urandom_range(0, 15) == 0) begin
        move_done = move_done | 1'($urandom);
        ldst_done = ldst_done | 1'($urandom);
      end
    end
  end

  // monitor: cycle-exact reference timeline plus in-order dispatch scoreboard
  initial begin : monitor
    bit inflight, cur_t, m_sel, m_err, ready_now, to_now, d;
    logic [PW-1:0] m_pay;
    int t_pop, done_at;
    cmd_t e, c;
    inflight = 0; cur_t = 0; m_sel = 0; m_err = 0; m_pay = '0; t_pop = 0; done_at = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete(); sb_q.delete();
        inflight = 0; cur_t = 0; m_sel = 0; m_err = 0; m_pay = '0; done_at = -1;
        continue;
      end
      chk("cmd_ready", cmd_ready, mq.size() != DEPTH);
      chk("fifo_count", fifo_count, mq.size());
      chk("move_start", move_start, inflight && (cyc == t_pop + 2) && !cur_t);
      chk("ldst_start", ldst_start, inflight && (cyc == t_pop + 2) && cur_t);
      chk("cmd_done", cmd_done, cyc == done_at);
      chk("busy", busy, inflight || (mq.size() != 0));
      chk("ram_sel", ram_sel, m_sel);
      chk("eng_payload", eng_payload, m_pay);
      chk("err_timeout", err_timeout, m_err);
      if (move_start || ldst_start) begin
        if (sb_q.size() == 0) chk("start_without_cmd", {move_start, ldst_start}, 0);
        else begin
          e = sb_q.pop_front();
          chk("sb_ldst_start", ldst_start, e.t);
          chk("sb_ram_sel", ram_sel, e.t);
          chk("sb_payload", eng_payload, e.p);
          $display("txn cycle %0d type=%0d payload=%h", cyc, e.t, e.p);
        end
      end
      ready_now = (mq.size() != DEPTH);
      to_now = 1'b0;
      if (!inflight && mq.size() > 0) begin
        c = mq.pop_front();
        inflight = 1; cur_t = c.t; t_pop = cyc; m_sel = c.t; m_pay = c.p;
      end else if (inflight && cyc >= t_pop + 3) begin
        d = cur_t ? ldst_done : move_done;
        if (d) begin
          done_at = cyc + 1; inflight = 0;
        end else if (cyc - (t_pop + 3) == TC - 1) begin
          to_now = 1; m_err = 1; done_at = cyc + 1; inflight = 0;
        end
      end
      if (err_clr && !to_now) m_err = 0;
      if (cmd_valid && ready_now) begin
        c.t = cmd_type; c.p = cmd_payload;
        mq.push_back(c);
      end
    end
  end

  initial begin : stim
    #2 chk_reset_outs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick(1);

    // single move, done three cycles into WAIT
    resp_en = 1; dmin = 3; dmax = 3;
    push(1'b0, 64'h1234); cmd_valid = 1'b0;
    wait_idle(); tick(2);
    chk("single_busy", busy, 0);

    // alternating types back-to-back
    dmin = 1; dmax = 5;
    push(1'b0, 64'hA0); push(1'b1, 64'hA1); push(1'b0, 64'hA2); cmd_valid = 1'b0;
    wait_idle(); tick(2);

    // done from the other engine must be ignored
    resp_wrong = 1; dmin = 4; dmax = 4;
    push(1'b0, 64'hB0); cmd_valid = 1'b0;
    wait_idle(); tick(2);
    resp_wrong = 0;

    // fill the FIFO with engines stalled; every command times out in order
    resp_en = 0;
    for (int i = 0; i < 5; i++) push(i[0], 64'hC0 + 64'(i));
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("full_count", fifo_count, 4);
    chk("full_ready", cmd_ready, 0);
    @(posedge clk); #1;
    push(1'b1, 64'hC5); cmd_valid = 1'b0;
    wait_idle(); tick(2);
    chk("full_timeout_err", err_timeout, 1);

    // clear, then a single timeout sets the flag again
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", err_timeout, 0);
    @(posedge clk); #1;
    push(1'b0, 64'hD0); cmd_valid = 1'b0;
    wait_idle(); tick(2);
    chk("timeout_err", err_timeout, 1);

    // asynchronous reset with one command in WAIT and two queued
    push(1'b1, 64'hE0); push(1'b0, 64'hE1); push(1'b1, 64'hE2); cmd_valid = 1'b0;
    tick(3);
    chk("pre_reset_count", fifo_count, 2);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_reset_count", fifo_count, 0);
    chk("post_reset_busy", busy, 0);
    @(posedge clk); #1;

    // random traffic with stray done pulses and occasional error clears
    resp_en = 1; noise_en = 1; dmin = 0; dmax = 10;
    for (int i = 0; i < 400; i++) begin
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) != 0) push(1'($urandom), {$urandom, $urandom});
      else begin
        cmd_valid = 1'b0;
        tick($urandom_range(1, 6));
      end
    end
    cmd_valid = 1'b0; err_clr = 1'b0; noise_en = 0;
    wait_idle(); tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_cmd_sched.md
Name: rf_cmd_sched

Overview:
- Schedules register-file move and load/store commands from the control unit onto the two RF engines, the move engine and the ldst engine.
- Buffers commands in a small FIFO and dispatches them strictly in order, one at a time.
- Drives the RF RAM mux select (ram_sel), so the select only changes while both engines are idle.
- Sits between the control unit and the RF wrapper, replacing static ram_sel driving, and adds completion and timeout reporting.

Parameters:
- PAYLOAD_W, 64: width of the opaque command payload forwarded to the engines.
- FIFO_DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- TIMEOUT_W, 16: width of the watchdog counter.
- TIMEOUT_CYCLES, 50000: WAIT cycles allowed before timeout; 0 disables the watchdog.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept a command
- cmd_type  input  1  0 = move, 1 = ldst
- cmd_payload  input  PAYLOAD_W  engine arguments, not interpreted here
- ram_sel  output  1  RF RAM mux select: 0 = move engine, 1 = ldst engine
- move_start  output  1  one-cycle start pulse to the move engine
- ldst_start  output  1  one-cycle start pulse to the ldst engine
- eng_payload  output  PAYLOAD_W  payload of the in-flight command
- move_done  input  1  move engine completion pulse
- ldst_done  input  1  ldst engine completion pulse
- cmd_done  output  1  one-cycle pulse when a command completes or times out
- busy  output  1  FIFO non-empty or FSM not IDLE
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of buffered commands
- err_timeout  output  1  sticky timeout flag
- err_clr  input  1  clears err_timeout

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO is emptied and the FSM enters IDLE.
  - ram_sel=0, move_start=0, ldst_start=0, eng_payload=0, cmd_done=0, err_timeout=0, fifo_count=0, busy=0.
  - A reset in the middle of a command aborts it without a done pulse; the engines are reset by the same rst_n.
- FIFO:
  - cmd_ready = (fifo_count != FIFO_DEPTH), purely a function of the count.
  - A push occurs on cmd_valid && cmd_ready.
  - A push and a pop in the same cycle are both honoured, so the count is unchanged.
  - While full, cmd_ready=0 even if a pop happens that cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, START, WAIT. All outputs are registered.
- IDLE: if the FIFO is non-empty, pop the head, latch cur_type and eng_payload, set ram_sel<=head type, go to SETUP. Otherwise stay in IDLE.
- SETUP: one settle cycle with ram_sel stable, then go to START.
- START: move_start or ldst_start is high for exactly this one cycle, selected by cur_type. The watchdog is cleared. Go to WAIT.
- WAIT:
  - Only the done input of the selected engine is sampled. The other engine's done is ignored.
  - On the selected done: cmd_done pulses the next cycle, and the FSM returns to IDLE that same cycle.
  - Otherwise the watchdog increments, saturating at its maximum.
  - If TIMEOUT_CYCLES != 0 and the watchdog equals TIMEOUT_CYCLES-1 with no done: set err_timeout, pulse cmd_done, return to IDLE.
  - A done arriving in the same cycle as the timeout counts as completion, with no error.
- Done pulses in IDLE, SETUP or START are ignored.
- ram_sel changes only on the IDLE to SETUP transition. It holds its value while idle and never changes during START or WAIT.
- eng_payload is held stable from SETUP until the next dispatch.
- Latency (push accepted in cycle N with an empty FIFO and the FSM in IDLE):
  - N+1: pop.
  - N+2: SETUP.
  - N+3: start pulse.
  - Selected done in cycle M: cmd_done in M+1.
  - A queued back-to-back command gets its next start pulse at M+3.
- err_timeout:
  - Sticky; cleared by err_clr.
  - If err_clr and a new timeout occur in the same cycle, the set wins.
  - Does not block further dispatch.
- busy = (state != IDLE) || (fifo_count != 0).

Test Plan:
- Single move: push type=0, payload=0x1234 in cycle 0 → ram_sel=0 and move_start high in cycle 3 with eng_payload=0x1234; move_done in cycle 7 → cmd_done in cycle 8, busy=0 in cycle 8 or 9.
- Alternating queue: push move, ldst, move back-to-back → ram_sel sequence 0,1,0; ram_sel changes only on IDLE to SETUP; each start is exactly 2 cycles after the preceding IDLE pop; exactly 3 cmd_done pulses.
- FIFO full: push 6 commands with the engines stalled → first is dispatched, 4 are buffered, cmd_ready=0 at fifo_count=4, sixth is held until a pop; order is preserved.
- Wrong done: ldst_done pulsed while a move is in WAIT → no cmd_done; the later move_done completes normally.
- Timeout: TIMEOUT_CYCLES=8, no done → err_timeout=1 and cmd_done pulse 8 cycles after entering WAIT; the next queued command still dispatches; err_clr clears the flag.
- Async reset with a command in WAIT and 2 queued → all outputs return to reset values immediately; no cmd_done; after release, fifo_count=0 and busy=0.
